// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Single-stage instruction fetch unit. It presents PC as a word address to a
//   combinational instruction memory, captures the returned word into an
//   output slot with a valid/ready handshake, and follows branch redirects
//   from execute. Fetch stops permanently (HALT) when the memory reports an
//   undefined word or PC leaves the memory. Only a reset leaves HALT.
//
// Parameters
//   MEM_DEPTH   number of 32-bit words in instruction memory
//   RESET_PC    word address loaded into PC on reset
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   Instruction_Add  out  word address to memory (equals PC)
//   Instruction      in   memory data for Instruction_Add, same cycle
//   Exit             in   memory flag: addressed word is undefined
//   Branch_Taken     in   redirect request from execute
//   Branch_Target    in   redirect word address
//   Out_Instruction  out  fetched instruction to decode
//   Out_PC           out  word address of Out_Instruction
//   Out_Valid        out  output slot holds a valid fetch
//   Out_Ready        in   decode accepts the slot this cycle
//   Halted           out  fetch stopped until reset
//   Fetch_Count      out  number of completed Out_Valid && Out_Ready cycles
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] Instruction_Add,
  input  logic [31:0] Instruction,
  input  logic        Exit,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PC,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic        Halted,
  output logic [31:0] Fetch_Count
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic        halted;
  logic [31:0] fetch_cnt;

  logic        slot_free;
  logic        handshake;
  logic        end_of_prog;

  // Address and count increments wrap modulo 2^32.
  function automatic logic [31:0] inc_wrap(input logic [31:0] value);
    return value + 32'd1;
  endfunction

  // The slot may be refilled when it is empty or being drained this cycle.
  always_comb begin
    slot_free   = !vld_p1 || Out_Ready;
    handshake   = vld_p1 && Out_Ready;
    end_of_prog = Exit || (pc_p0 >= PC_LIMIT);
  end

  // ---- stage p0 -> p1: address PC, capture returned word into output slot
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      pc_p0     <= RESET_PC;
      vld_p1    <= 1'b0;
      instr_p1  <= 32'd0;
      pc_p1     <= 32'd0;
      halted    <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      // A handshake is counted even when the slot is flushed the same cycle.
      if (handshake) begin
        fetch_cnt <= inc_wrap(fetch_cnt);
      end

      case (state)
        RUN: begin
          if (Branch_Taken) begin
            // Redirect wins over stall, capture and halt; the slot is dropped.
            pc_p0  <= Branch_Target;
            vld_p1 <= 1'b0;
          end else if (slot_free) begin
            if (end_of_prog) begin
              // PC is held so Instruction_Add keeps pointing at the stop word.
              vld_p1 <= 1'b0;
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              instr_p1 <= Instruction;
              pc_p1    <= pc_p0;
              vld_p1   <= 1'b1;
              pc_p0    <= inc_wrap(pc_p0);
            end
          end
        end

        HALT: begin
          vld_p1 <= 1'b0;
          halted <= 1'b1;
        end

        default: begin
          state  <= HALT;
          vld_p1 <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign Instruction_Add = pc_p0;
  assign Out_Instruction = instr_p1;
  assign Out_PC          = pc_p1;
  assign Out_Valid       = vld_p1;
  assign Halted          = halted;
  assign Fetch_Count     = fetch_cnt;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 32;

  logic        clock;
  logic        reset;
  logic [31:0] instruction_add;
  logic [31:0] instruction;
  logic        exit_flag;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  // Behavioural memory: 64 words of content, words below prog_len are defined.
  logic [31:0] mem [0:63];
  logic [31:0] prog_len;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a < 32'd64) return mem[a[5:0]];
    return 32'hDEAD_BEEF;
  endfunction

  assign instruction = mem_at(instruction_add);
  assign exit_flag   = (instruction_add >= prog_len);

  instruction_fetch #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clock          (clock),
    .reset          (reset),
    .Instruction_Add(instruction_add),
    .Instruction    (instruction),
    .Exit           (exit_flag),
    .Branch_Taken   (branch_taken),
    .Branch_Target  (branch_target),
    .Out_Instruction(out_instruction),
    .Out_PC         (out_pc),
    .Out_Valid      (out_valid),
    .Out_Ready      (out_ready),
    .Halted         (halted),
    .Fetch_Count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    prog_len      = 32'd16;
    out_ready     = 1'b1;
    reset         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'd7;
    step();
    checks++;
    if ({out_valid, halted} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got valid=%0b halted=%0b want 0 0", out_valid, halted);
    end
    checks++;
    if (instruction_add !== 32'd0 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_pc_count got addr=%0d count=%0d want 0 0", instruction_add, fetch_count);
    end
    checks++;
    if (out_pc !== 32'd0 || out_instruction !== 32'd0) begin
      failures++;
      $display("FAIL reset_slot got pc=%0d instr=%h want 0 0", out_pc, out_instruction);
    end
    branch_taken = 1'b0;
    reset        = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_sequential();
    prog_len  = 32'd4;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instruction !== mem[i]) begin
        failures++;
        $display("FAIL seq_word%0d got v=%0b pc=%0d instr=%h want 1 %0d %h",
                 i, out_valid, out_pc, out_instruction, i, mem[i]);
      end
    end
    step();
    checks++;
    if (fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL seq_count got %0d want 4", fetch_count);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_stall();
    prog_len  = 32'd16;
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd2 || out_instruction !== mem[2] ||
          instruction_add !== 32'd3 || fetch_count !== 32'd2) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%0b pc=%0d instr=%h addr=%0d cnt=%0d want 1 2 %h 3 2",
                 i, out_valid, out_pc, out_instruction, instruction_add, fetch_count, mem[2]);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instruction !== mem[3] || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL stall_release got v=%0b pc=%0d instr=%h cnt=%0d want 1 3 %h 3",
               out_valid, out_pc, out_instruction, fetch_count, mem[3]);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_end_of_program();
    prog_len  = 32'd5;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instruction !== mem[i]) begin
        failures++;
        $display("FAIL eop_word%0d got v=%0b pc=%0d instr=%h want 1 %0d %h",
                 i, out_valid, out_pc, out_instruction, i, mem[i]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b1 || instruction_add !== 32'd5 || fetch_count !== 32'd5) begin
      failures++;
      $display("FAIL eop_halt got v=%0b h=%0b addr=%0d cnt=%0d want 0 1 5 5",
               out_valid, halted, instruction_add, fetch_count);
    end
    branch_taken  = 1'b1;
    branch_target = 32'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || instruction_add !== 32'd5 || fetch_count !== 32'd5) begin
        failures++;
        $display("FAIL halt_ignores_branch%0d got v=%0b h=%0b addr=%0d cnt=%0d want 0 1 5 5",
                 i, out_valid, halted, instruction_add, fetch_count);
      end
    end
    branch_taken = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_branch_stall();
    prog_len  = 32'd16;
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    out_ready     = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'd10;
    step();
    checks++;
    if (out_valid !== 1'b0 || instruction_add !== 32'd10 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL branch_flush got v=%0b addr=%0d cnt=%0d want 0 10 1",
               out_valid, instruction_add, fetch_count);
    end
    branch_taken = 1'b0;
    out_ready    = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd10 || out_instruction !== mem[10]) begin
      failures++;
      $display("FAIL branch_target_fetch got v=%0b pc=%0d instr=%h want 1 10 %h",
               out_valid, out_pc, out_instruction, mem[10]);
    end
    step();
    checks++;
    if (out_pc !== 32'd11 || fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL branch_follow got pc=%0d cnt=%0d want 11 2", out_pc, fetch_count);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_out_of_range();
    prog_len  = 32'd64;
    out_ready = 1'b1;
    do_reset();
    step();
    branch_taken  = 1'b1;
    branch_target = 32'd32;
    step();
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || instruction_add !== 32'd32 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL oor_load got v=%0b h=%0b addr=%0d cnt=%0d want 0 0 32 1",
               out_valid, halted, instruction_add, fetch_count);
    end
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || instruction_add !== 32'd32 || fetch_count !== 32'd1) begin
        failures++;
        $display("FAIL oor_halt%0d got v=%0b h=%0b addr=%0d cnt=%0d want 0 1 32 1",
                 i, out_valid, halted, instruction_add, fetch_count);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_in_halt();
    reset = 1'b1;
    step();
    checks++;
    if (halted !== 1'b0 || instruction_add !== 32'd0 || out_valid !== 1'b0 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL halt_reset got h=%0b addr=%0d v=%0b cnt=%0d want 0 0 0 0",
               halted, instruction_add, out_valid, fetch_count);
    end
    reset     = 1'b0;
    prog_len  = 32'd16;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instruction !== mem[0]) begin
      failures++;
      $display("FAIL halt_resume got v=%0b pc=%0d instr=%h want 1 0 %h",
               out_valid, out_pc, out_instruction, mem[0]);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model of the observable fetch behaviour, advanced one clock.
  logic [31:0] m_pc, m_instr, m_opc, m_count;
  logic        m_valid, m_halt;

  task automatic model_step();
    logic [31:0] n_pc, n_instr, n_opc, n_count;
    logic        n_valid, n_halt;
    n_pc = m_pc; n_instr = m_instr; n_opc = m_opc; n_count = m_count;
    n_valid = m_valid; n_halt = m_halt;
    if (reset) begin
      n_pc = 32'd0; n_instr = 32'd0; n_opc = 32'd0; n_count = 32'd0;
      n_valid = 1'b0; n_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_valid && out_ready) n_count = m_count + 32'd1;
      if (branch_taken) begin
        n_pc    = branch_target;
        n_valid = 1'b0;
      end else if (!m_valid || out_ready) begin
        if (m_pc >= prog_len || m_pc >= 32'(DEPTH)) begin
          n_valid = 1'b0;
          n_halt  = 1'b1;
        end else begin
          n_instr = mem_at(m_pc);
          n_opc   = m_pc;
          n_valid = 1'b1;
          n_pc    = m_pc + 32'd1;
        end
      end
    end
    step();
    m_pc = n_pc; m_instr = n_instr; m_opc = n_opc; m_count = n_count;
    m_valid = n_valid; m_halt = n_halt;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int round = 0; round < 4; round++) begin
      prog_len     = 32'($urandom_range(8, 40));
      branch_taken = 1'b0;
      out_ready    = 1'b1;
      reset        = 1'b1;
      model_step();
      for (int c = 0; c < 150; c++) begin
        reset         = ($urandom_range(0, 99) == 0);
        out_ready     = ($urandom_range(0, 9) < 7);
        branch_taken  = ($urandom_range(0, 9) == 0);
        branch_target = 32'($urandom_range(0, 40));
        model_step();
        checks++;
        if (instruction_add !== m_pc || out_valid !== m_valid || halted !== m_halt ||
            fetch_count !== m_count ||
            (m_valid && (out_pc !== m_opc || out_instruction !== m_instr))) begin
          failures++;
          bad++;
          if (bad <= 10)
            $display("FAIL rand_r%0d_c%0d got addr=%0d v=%0b h=%0b cnt=%0d pc=%0d instr=%h want %0d %0b %0b %0d %0d %h",
                     round, c, instruction_add, out_valid, halted, fetch_count, out_pc, out_instruction,
                     m_pc, m_valid, m_halt, m_count, m_opc, m_instr);
        end
      end
    end
    reset        = 1'b0;
    branch_taken = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    out_ready     = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    prog_len      = 32'd16;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_end_of_program();
    test_branch_stall();
    test_out_of_range();
    test_reset_in_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, number of 32-bit words in instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 0, word address loaded into PC on reset.
REQ-003 SHALL have clock, an input of width 1: the single clock, all state updates on the rising edge.
REQ-004 SHALL have reset, an input of width 1: synchronous, active-high.
REQ-005 SHALL have Instruction_Add, an output of width 32: word address driven to instruction memory, equal to PC.
REQ-006 SHALL have Instruction, an input of width 32: memory data for Instruction_Add, valid in the same cycle (combinational read).
REQ-007 SHALL have Exit, an input of width 1: memory flag, 1 when the addressed word is undefined.
REQ-008 SHALL have Branch_Taken, an input of width 1: redirect request from execute.
REQ-009 SHALL have Branch_Target, an input of width 32: redirect word address.
REQ-010 SHALL have Out_Instruction, an output of width 32: fetched instruction to decode.
REQ-011 SHALL have Out_PC, an output of width 32: word address of Out_Instruction.
REQ-012 SHALL have Out_Valid, an output of width 1: Out_Instruction/Out_PC hold a valid fetch.
REQ-013 SHALL have Out_Ready, an input of width 1: decode accepts this cycle.
REQ-014 SHALL have Halted, an output of width 1: fetch stopped permanently until reset.
REQ-015 SHALL have Fetch_Count, an output of width 32: number of completed Out_Valid&&Out_Ready handshakes.

Function
REQ-016 SHALL implement a two-state FSM: RUN, HALT; HALT absorbing until reset.
REQ-017 SHALL drive Instruction_Add = PC combinationally from the PC register in every state.
REQ-018 SHALL define "slot free" as Out_Valid==0 or Out_Ready==1.
REQ-019 SHALL, in RUN with slot free, Branch_Taken==0, Exit==0 and PC<MEM_DEPTH, register Out_Instruction<=Instruction, Out_PC<=PC, Out_Valid<=1, PC<=PC+1 (latency one cycle from address to Out_Valid).
REQ-020 SHALL, in RUN with Out_Valid==1 and Out_Ready==0, hold PC, Out_Instruction, Out_PC and Out_Valid unchanged (stall, no data loss, no duplicate).
REQ-021 SHALL, in RUN with slot free, Branch_Taken==0 and (Exit==1 or PC>=MEM_DEPTH), not capture, set Out_Valid<=0, hold PC, go to HALT, Halted<=1.
REQ-022 SHALL, in RUN with Branch_Taken==1, set PC<=Branch_Target and Out_Valid<=0 (flush) regardless of Out_Ready, Exit or stall; branch has priority over capture and halt.
REQ-023 SHALL count a handshake for Fetch_Count when Out_Valid&&Out_Ready, including the cycle a flush occurs.
REQ-024 SHALL, in HALT, ignore Branch_Taken, Exit and Instruction; hold PC; Out_Valid stays 0; Halted stays 1.
REQ-025 SHALL treat a Branch_Target>=MEM_DEPTH as legal to load; the halt check of REQ-021 applies on the next slot-free cycle.
REQ-026 SHALL compute PC+1 and Fetch_Count+1 modulo 2^32.

Reset
REQ-027 SHALL, on reset==1 at a rising edge, set PC<=RESET_PC, state<=RUN, Out_Valid<=0, Out_Instruction<=0, Out_PC<=0, Halted<=0, Fetch_Count<=0.
REQ-028 SHALL give reset priority over Branch_Taken, Exit and handshakes, including reset asserted in HALT or mid-stall.

Verification
REQ-029 SHALL cover sequential fetch: memory words 0..3 defined, Out_Ready=1 -> Out_PC 0,1,2,3 on consecutive cycles, Out_Instruction matches memory, Fetch_Count=4 after four handshakes.
REQ-030 SHALL cover stall: Out_Valid=1 at Out_PC=2, Out_Ready=0 for 3 cycles -> outputs and Instruction_Add=3 held; Out_Ready=1 -> Out_PC=3 next cycle, no skip or repeat.
REQ-031 SHALL cover end of program: words 0..4 defined, word 5 undefined (Exit=1) -> five handshakes, then Out_Valid=0, Halted=1, Instruction_Add stays 5, Fetch_Count=5.
REQ-032 SHALL cover branch during stall: Out_Valid=1, Out_Ready=0, Branch_Taken=1, Branch_Target=10 -> next cycle Out_Valid=0, Instruction_Add=10; following cycle Out_PC=10.
REQ-033 SHALL cover out-of-range: Branch_Target=32 with MEM_DEPTH=32 -> PC=32 then HALT, Halted=1, no fetch issued.
REQ-034 SHALL cover reset in HALT: reset=1 one cycle -> Halted=0, Instruction_Add=0, Out_Valid=0, Fetch_Count=0, fetch resumes at word 0.
